// File: rtl/config_pkg.sv
// Shared configuration for the SPI datapath: word width and the default
// sizing of the transmitter arbiter.
package config_pkg;
  localparam int P_DATA_WIDTH   = 8;
  localparam int P_NUM_REQ_DEF  = 4;
  localparam int P_ISSUE_TO_DEF = 16;
endpackage

// File: rtl/spi_tx_arbiter_rr_arbiter.sv
// Rotating-priority selector: picks the first asserted request at or above
// rr_ptr_i, wrapping around, and returns it one-hot and encoded.
module rr_arbiter #(
  parameter int P_NUM_REQ = 4,
  localparam int ID_W = $clog2(P_NUM_REQ)
) (
  input  logic [P_NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]      rr_ptr_i,
  output logic [P_NUM_REQ-1:0] grant_o,
  output logic [ID_W-1:0]      id_o,
  output logic                 any_o
);

  int   idx;
  logic found;

  always_comb begin
    grant_o = '0;
    id_o    = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < P_NUM_REQ; k++) begin
      idx = (int'(rr_ptr_i) + k) % P_NUM_REQ;
      if (!found && req_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        id_o         = ID_W'(idx);
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/spi_tx_arbiter.sv
// Round-robin sharing of one SPI transmitter between P_NUM_REQ producers:
// capture the winner's word, issue it, wait for the shift-out, report done/err.
module spi_tx_arbiter
  import config_pkg::*;
#(
  parameter int P_NUM_REQ    = P_NUM_REQ_DEF,
  parameter int P_DATA_WIDTH = config_pkg::P_DATA_WIDTH,
  parameter int P_ISSUE_TO   = P_ISSUE_TO_DEF,
  localparam int ID_W = $clog2(P_NUM_REQ)
) (
  input  logic                              clk_100,
  input  logic                              s_rst,
  input  logic [P_NUM_REQ-1:0]              req_valid,
  input  logic [P_NUM_REQ*P_DATA_WIDTH-1:0] req_data,
  output logic [P_NUM_REQ-1:0]              req_ready,
  output logic [P_NUM_REQ-1:0]              req_done,
  output logic [P_NUM_REQ-1:0]              req_err,
  output logic                              tx_valid,
  output logic [P_DATA_WIDTH-1:0]           tx_data,
  input  logic                              tx_ready,
  output logic [ID_W-1:0]                   grant_id,
  output logic                              busy,
  output logic [1:0]                        dbg_state
);

  localparam int CNT_W = $clog2(P_ISSUE_TO);

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, DONE} arb_state_t;

  arb_state_t              state_q, state_d;
  logic [ID_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]         grant_id_q, grant_id_d;
  logic [P_DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                    tx_valid_q, tx_valid_d;
  logic [P_NUM_REQ-1:0]    err_q, err_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic [P_NUM_REQ-1:0]    arb_grant;
  logic [ID_W-1:0]         arb_id;
  logic                    arb_any;
  logic                    accept;
  logic [ID_W-1:0]         next_ptr;

  rr_arbiter #(.P_NUM_REQ(P_NUM_REQ)) u_rr (
    .req_i    (req_valid),
    .rr_ptr_i (rr_ptr_q),
    .grant_o  (arb_grant),
    .id_o     (arb_id),
    .any_o    (arb_any)
  );

  // Handshakes: a requester word moves on the edge where req_valid[i] &
  // req_ready[i]; the transmitter takes tx_data while tx_valid & tx_ready.
  assign accept    = (state_q == IDLE) && tx_ready && arb_any && !s_rst;
  assign req_ready = accept ? arb_grant : '0;
  assign next_ptr  = (grant_id_q == ID_W'(P_NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    err_d      = '0;
    cnt_d      = cnt_q;
    req_done   = '0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          tx_data_d  = req_data[int'(arb_id) * P_DATA_WIDTH +: P_DATA_WIDTH];
          grant_id_d = arb_id;
          tx_valid_d = 1'b1;
          cnt_d      = '0;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        // Ready dropping means the transmitter took the word; it beats a timeout.
        if (!tx_ready) begin
          tx_valid_d = 1'b0;
          cnt_d      = '0;
          state_d    = BUSY;
        end else if (cnt_q == CNT_W'(P_ISSUE_TO - 1)) begin
          err_d[grant_id_q] = 1'b1;
          rr_ptr_d          = next_ptr;
          tx_valid_d        = 1'b0;
          cnt_d             = '0;
          state_d           = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      BUSY: begin
        if (tx_ready) state_d = DONE;
      end
      DONE: begin
        req_done[grant_id_q] = 1'b1;
        rr_ptr_d             = next_ptr;
        state_d              = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_100) begin
    if (s_rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      err_q      <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign tx_valid  = tx_valid_q;
  assign tx_data   = tx_data_q;
  assign grant_id  = grant_id_q;
  assign req_err   = err_q;
  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// Directed bench for spi_tx_arbiter with a behavioural SPI transmitter
// (ready drops 3 cycles after valid, SCK = clk/8, MSB first).
module tb_spi_tx_arbiter;
  localparam int NR = 4;
  localparam int W  = 8;

  logic            clk_100 = 1'b0;
  logic            s_rst;
  logic [NR-1:0]   req_valid, req_ready, req_done, req_err;
  logic [NR*W-1:0] req_data;
  logic            tx_valid;
  logic [W-1:0]    tx_data;
  logic            tx_ready;
  logic [1:0]      grant_id;
  logic            busy;
  logic [1:0]      dbg_state;

  always #5 clk_100 = ~clk_100;

  spi_tx_arbiter dut (
    .clk_100   (clk_100),
    .s_rst     (s_rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .req_done  (req_done),
    .req_err   (req_err),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .grant_id  (grant_id),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // transmitter model
  logic         m_ready;
  logic [1:0]   m_st;
  logic [2:0]   m_cnt, m_bit;
  logic [W-1:0] m_word;
  logic [W-1:0] m_rx = '0;
  logic         stuck = 1'b0;
  logic         hold_low = 1'b0;

  assign tx_ready = m_ready & ~hold_low;

  always @(posedge clk_100) begin
    if (s_rst) begin
      m_ready <= 1'b1;
      m_st    <= 2'd0;
      m_cnt   <= 3'd0;
      m_bit   <= 3'd0;
      m_word  <= '0;
    end else begin
      case (m_st)
        2'd0: if (tx_valid && tx_ready && !stuck) begin
          m_word <= tx_data;
          m_cnt  <= 3'd1;
          m_st   <= 2'd1;
        end
        2'd1: if (m_cnt == 3'd2) begin
          m_ready <= 1'b0;
          m_cnt   <= 3'd0;
          m_bit   <= 3'd7;
          m_st    <= 2'd2;
        end else begin
          m_cnt <= m_cnt + 3'd1;
        end
        default: begin
          m_cnt <= m_cnt + 3'd1;
          if (m_cnt == 3'd7) begin
            m_rx <= {m_rx[W-2:0], m_word[m_bit]};
            if (m_bit == 3'd0) begin
              m_ready <= 1'b1;
              m_st    <= 2'd0;
            end else begin
              m_bit <= m_bit - 3'd1;
            end
          end
        end
      endcase
    end
  end

  // checking
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic int oh_idx(input logic [NR-1:0] v);
    oh_idx = -1;
    for (int i = 0; i < NR; i++) if (v[i]) oh_idx = i;
  endfunction

  // monitor and scoreboard
  logic [W-1:0] exp_q[$];
  int grant_log[$];
  int neg_cyc = 0, acc_cnt = 0, done_tot = 0, err_tot = 0;
  int acc_neg = 0, err_neg = 0, txv_run = 0, txv_last = 0;
  int done_cnt[NR];
  int err_cnt[NR];

  always @(negedge clk_100) begin
    int mi;
    neg_cyc++;
    if (s_rst) begin
      exp_q.delete();
      txv_run = 0;
    end else begin
      if (|(req_valid & req_ready)) begin
        mi = oh_idx(req_valid & req_ready);
        grant_log.push_back(mi);
        acc_cnt++;
        acc_neg = neg_cyc;
        exp_q.push_back(req_data[mi*W +: W]);
      end
      if (|req_done) begin
        mi = oh_idx(req_done);
        done_cnt[mi]++;
        done_tot++;
        if (exp_q.size() == 0) check("sb_underflow", 32'd0, 32'd1);
        else check("mosi", 32'(m_rx), 32'(exp_q.pop_front()));
      end
      if (|req_err) begin
        mi = oh_idx(req_err);
        err_cnt[mi]++;
        err_tot++;
        err_neg = neg_cyc;
        if (exp_q.size() > 0) exp_q.delete(0);
      end
      if (tx_valid) txv_run++;
      else if (txv_run > 0) begin
        txv_last = txv_run;
        txv_run  = 0;
      end
    end
  end

  // driver tasks
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk_100);
      #1;
    end
  endtask

  task automatic clear_logs();
    grant_log.delete();
    acc_cnt  = 0;
    done_tot = 0;
    err_tot  = 0;
    for (int i = 0; i < NR; i++) begin
      done_cnt[i] = 0;
      err_cnt[i]  = 0;
    end
  endtask

  task automatic wait_acc(input int target, input int bound, input string tag);
    int b = 0;
    while (acc_cnt < target && b < bound) begin
      step();
      b++;
    end
    check(tag, acc_cnt, target);
  endtask

  task automatic wait_done(input int target, input int bound, input string tag);
    int b = 0;
    while (done_tot < target && b < bound) begin
      step();
      b++;
    end
    check(tag, done_tot, target);
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_g[5];
    int b;
    for (int i = 0; i < NR; i++) begin
      done_cnt[i] = 0;
      err_cnt[i]  = 0;
    end
    s_rst     = 1'b1;
    req_valid = 4'b1111;
    req_data  = 32'h44332211;

    // reset values, and no ready while reset is held
    step(3);
    check("rst_req_ready", req_ready, 4'b0000);
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_grant_id", grant_id, 2'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_state", dbg_state, 2'd0);
    check("rst_done_err", {req_done, req_err}, 8'h00);
    req_valid = '0;
    s_rst     = 1'b0;
    step(2);

    // single request from requester 1
    clear_logs();
    req_data = '0;
    req_data[1*W +: W] = 8'hA5;
    req_valid = 4'b0010;
    #1;
    check("single_ready", req_ready, 4'b0010);
    wait_acc(1, 20, "single_acc");
    req_valid = '0;
    check("single_ready_drop", req_ready, 4'b0000);
    check("single_grant", grant_id, 2'd1);
    check("single_txv", tx_valid, 1'b1);
    check("single_txdata", tx_data, 8'hA5);
    wait_done(1, 200, "single_done");
    step(5);
    check("single_done1", done_cnt[1], 1);
    check("single_txv_len", txv_last, 4);
    check("single_busy_end", busy, 1'b0);

    // contention: rr pointer back to 0, all four held
    s_rst = 1'b1;
    step();
    s_rst = 1'b0;
    clear_logs();
    for (int i = 0; i < NR; i++) req_data[i*W +: W] = 8'h30 + 8'(i);
    req_valid = 4'b1111;
    wait_acc(5, 600, "cont_acc");
    req_valid = '0;
    wait_done(5, 300, "cont_done");
    exp_g = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 5; i++) check($sformatf("cont_grant%0d", i), grant_log[i], exp_g[i]);
    check("cont_done0", done_cnt[0], 2);
    check("cont_done1", done_cnt[1], 1);
    check("cont_done2", done_cnt[2], 1);
    check("cont_done3", done_cnt[3], 1);

    // starvation: req 0 busy, req 3 joins once
    clear_logs();
    req_data[0*W +: W] = 8'h0F;
    req_data[3*W +: W] = 8'hE7;
    req_valid = 4'b0001;
    wait_acc(1, 20, "starve_acc0");
    req_valid = 4'b1001;
    wait_acc(2, 300, "starve_acc3");
    req_valid = '0;
    wait_done(2, 300, "starve_done");
    check("starve_first", grant_log[0], 0);
    check("starve_second", grant_log[1], 3);
    check("starve_done3", done_cnt[3], 1);

    // issue timeout with a transmitter that never drops ready
    clear_logs();
    stuck = 1'b1;
    req_data[2*W +: W] = 8'h5C;
    req_valid = 4'b0100;
    wait_acc(1, 20, "to_acc");
    req_valid = '0;
    b = 0;
    while (err_tot < 1 && b < 40) begin
      step();
      b++;
    end
    check("to_err_seen", err_tot, 1);
    check("to_dist", err_neg - (acc_neg + 1), 16);
    check("to_err_idx", err_cnt[2], 1);
    check("to_txv", tx_valid, 1'b0);
    check("to_err_pulse", req_err, 4'b0000);
    check("to_no_done", done_tot, 0);
    stuck = 1'b0;
    clear_logs();
    req_data[3*W +: W] = 8'h96;
    req_valid = 4'b1101;
    wait_acc(1, 20, "to_next_acc");
    req_valid = '0;
    check("to_next_grant", grant_log[0], 3);
    wait_done(1, 200, "to_next_done");
    check("to_next_done3", done_cnt[3], 1);

    // back-pressure at idle
    clear_logs();
    req_data[0*W +: W] = 8'h81;
    hold_low  = 1'b1;
    req_valid = 4'b0001;
    step(8);
    check("bp_no_acc", acc_cnt, 0);
    check("bp_ready", req_ready, 4'b0000);
    check("bp_state", dbg_state, 2'd0);
    check("bp_busy", busy, 1'b0);
    hold_low = 1'b0;
    #1;
    check("bp_release_ready", req_ready, 4'b0001);
    wait_acc(1, 5, "bp_acc");
    req_valid = '0;
    wait_done(1, 200, "bp_done");

    // reset while the word is shifting
    clear_logs();
    req_data[1*W +: W] = 8'h42;
    req_valid = 4'b0010;
    wait_acc(1, 20, "rb_acc");
    req_valid = '0;
    b = 0;
    while (dbg_state != 2'd2 && b < 20) begin
      step();
      b++;
    end
    check("rb_reach_busy", dbg_state, 2'd2);
    step(10);
    s_rst = 1'b1;
    step();
    check("rb_txv", tx_valid, 1'b0);
    check("rb_busy", busy, 1'b0);
    check("rb_state", dbg_state, 2'd0);
    check("rb_pulses", {req_done, req_err}, 8'h00);
    s_rst = 1'b0;
    step(100);
    check("rb_no_done", done_tot, 0);
    check("rb_no_err", err_tot, 0);
    req_data[0*W +: W] = 8'hC3;
    req_valid = 4'b1111;
    wait_acc(2, 20, "rb_fresh_acc");
    req_valid = '0;
    check("rb_fresh_grant", grant_log[1], 0);
    check("rb_fresh_gid", grant_id, 2'd0);
    wait_done(1, 200, "rb_fresh_done");
    check("rb_fresh_done0", done_cnt[0], 1);
    step(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
